tcp_vlg_ack_sched: RTL
======================

// Module: tcp_vlg_ack_sched
// PURPOSE
//  Delayed-Ack scheduler downstream of the TCP SACK/receive-queue stage.
//  Consumes the local ack number, current SACK option and force-update strobe, and decides when an Ack is sent.
//  Triggers: packet-count threshold, idle timeout, or forced update.
//  Issues a held request with a frozen {ack, sack} snapshot to the TCP transmit engine and waits for acceptance.
// PARAMETERS
//  TIMEOUT           1250  clocks an unacked loc_ack may wait before an Ack is forced (0 = ack immediately)
//  FORCE_ACK_PACKETS 5     payload packets received since last Ack that force an Ack (>=1)
//  VERBOSE           0     1 = $display trigger/send events (simulation only)
//  DUT_STRING        ""    prefix for VERBOSE messages
// PORTS
//  clk       in   1               system clock
//  rst_n     in   1               synchronous reset, active low
//  status    in   tcp_stat_t      connection state; scheduler active only when tcp_connected
//  init      in   1               load sent_ack from init_ack (connection establishment)
//  init_ack  in   32              initial local ack (from TCB)
//  loc_ack   in   32              current local ack from SACK stage
//  sack      in   tcp_opt_sack_t  current SACK option from SACK stage
//  upd       in   1               pulse: force immediate Ack (SACK changed)
//  pkt_rx    in   1               pulse: one payload-bearing packet accepted for this connection
//  req       out  1               Ack send request, held until accepted
//  req_ack   out  32              ack number to send (stable while req)
//  req_sack  out  tcp_opt_sack_t  SACK option to send (stable while req)
//  acc       in   1               transmit engine accepted request (valid only while req=1)
// BEHAVIOUR
//  Reset (rst_n=0): req=0, req_ack=0, req_sack=0, sent_ack=0, pkt_cnt=0, tmr=0, pend=0, fsm=IDLE_S.
//  init=1 (not in reset): sent_ack<=init_ack; counters, req and pend cleared; fsm<=IDLE_S. init wins over all other inputs.
//  status!=tcp_connected: next cycle fsm<=IDLE_S, req<=0, counters cleared.
//    An in-flight request is dropped; sent_ack is unchanged.
//  FSM states:
//   IDLE_S  loc_ack==sent_ack and no pend.
//           -> DLY_S when loc_ack!=sent_ack or pkt_rx.
//           -> REQ_S directly on upd.
//   DLY_S   tmr increments each clock, saturating at TIMEOUT. pkt_cnt increments on pkt_rx, saturating.
//           -> REQ_S when upd, or pkt_cnt+pkt_rx>=FORCE_ACK_PACKETS, or tmr==TIMEOUT.
//   REQ_S   entry cycle: req<=1, req_ack<=loc_ack, req_sack<=sack (snapshot, frozen until accept).
//           On acc: req<=0, sent_ack<=req_ack, tmr<=0, pkt_cnt<=0.
//             Then -> DLY_S if pend or loc_ack!=req_ack, else -> IDLE_S.
//  pend: set by upd or pkt_rx while in REQ_S; cleared on leaving REQ_S.
//    pkt_rx in REQ_S also increments pkt_cnt after the clear, so pkt_cnt=1 on exit.
//  Latency: trigger seen at cycle N -> req=1 at N+1. acc at M -> req=0 at M+1; a new req earliest at M+2.
//  acc while req=0 is ignored.
//  Ack comparison uses 32-bit != only (sequence wrap-safe); no magnitude compare.
//  TIMEOUT=0 means DLY_S exits on its first cycle.
//    FORCE_ACK_PACKETS=1 means every pkt_rx triggers.
//  Simultaneous upd and pkt_rx in DLY_S: a single request; pkt_cnt cleared on accept.
//  Timer width $clog2(TIMEOUT+1), minimum 1. pkt_cnt width $clog2(FORCE_ACK_PACKETS+1).
// STRUCTURE
//  tcp_vlg_pkg: add ack_sched_fsm_t enum {IDLE_S, DLY_S, REQ_S}. Existing tcp_stat_t and tcp_opt_sack_t are reused.
//  Sub-module eth_vlg_sat_cnt #(W,MAX): saturating counter with clr/inc; instantiated for tmr and pkt_cnt.
//  All else is flat in this module; single always_ff plus a combinational trigger decode.
// TESTING
//  1 init_ack=32'h1000, connected; loc_ack->32'h1010 with 5 pkt_rx pulses 2 clk apart -> req after 5th pulse+1 clk, req_ack=32'h1010.
//  2 Single pkt_rx, loc_ack=32'h1004, TIMEOUT=20, no other stimulus -> req asserts 21-22 clk later; hold acc=0 for 10 clk -> req/req_ack stable.
//  3 upd pulse in IDLE_S with sack block0 {32'h2000,32'h2100} -> req next clk; req_sack equals that snapshot.
//    sack changes before acc -> req_sack unchanged.
//  4 pkt_rx and loc_ack change during REQ_S, acc given -> fsm to DLY_S, pkt_cnt=1; second req carries newer loc_ack.
//  5 Wrap: init_ack=32'hFFFF_FFF8, loc_ack->32'h0000_0008, FORCE trigger -> req_ack=32'h0000_0008; sent_ack updated after acc.
//  6 req=1 then status->tcp_closed, or rst_n=0 mid-request -> req=0 next clk, all outputs at reset values, no acc effect.

Source files
------------

// File: rtl/tcp_vlg_pkg.sv
// Shared TCP types for the per-connection receive/ack path.
// Connection status, SACK option layout and ack scheduler states.
package tcp_vlg_pkg;

  typedef enum logic [2:0] {
    tcp_closed,
    tcp_listening,
    tcp_connecting,
    tcp_connected,
    tcp_disconnecting
  } tcp_stat_t;

  typedef struct packed {
    logic [31:0] left;
    logic [31:0] right;
  } sack_blk_t;

  typedef struct packed {
    sack_blk_t [3:0] sack_blk;
    logic      [3:0] val;
  } tcp_opt_sack_t;

  typedef enum logic [1:0] {
    IDLE_S,
    DLY_S,
    REQ_S
  } ack_sched_fsm_t;

endpackage

// File: rtl/eth_vlg_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// An increment coincident with clear yields 1, not 0.
module eth_vlg_sat_cnt #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= (i_inc && MAX > 0) ? W'(1) : '0;
    end else if (i_inc && r_cnt != W'(MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/tcp_vlg_ack_sched.sv
// Delayed-Ack scheduler: packet count, idle timeout or forced update
// raise a held request carrying a frozen {ack, sack} snapshot.
module tcp_vlg_ack_sched
  import tcp_vlg_pkg::*;
#(
  parameter int    TIMEOUT           = 1250,
  parameter int    FORCE_ACK_PACKETS = 5,
  parameter int    VERBOSE           = 0,
  parameter string DUT_STRING        = ""
) (
  input  logic          clk,
  input  logic          rst_n,
  input  tcp_stat_t     status,
  input  logic          init,
  input  logic [31:0]   init_ack,
  input  logic [31:0]   loc_ack,
  input  tcp_opt_sack_t sack,
  input  logic          upd,
  input  logic          pkt_rx,
  output logic          req,
  output logic [31:0]   req_ack,
  output tcp_opt_sack_t req_sack,
  input  logic          acc
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CW = $clog2(FORCE_ACK_PACKETS + 1);

  ack_sched_fsm_t r_fsm;
  logic [31:0]    r_sent_ack;
  logic           r_pend;
  logic           r_req;
  logic [31:0]    r_req_ack;
  tcp_opt_sack_t  r_req_sack;

  logic          w_conn;
  logic          w_live;
  logic          w_acc;
  logic          w_hold;
  logic          w_cnt_clr;
  logic          w_fire;
  logic          w_go_req;
  logic          w_go_dly;
  logic [TW-1:0] w_tmr;
  logic [CW-1:0] w_pkt_cnt;
  logic          w_unused;

  assign w_unused = (VERBOSE != 0) || (DUT_STRING != "");

  assign w_conn    = (status == tcp_connected);
  assign w_live    = !init && w_conn;
  assign w_acc     = (r_fsm == REQ_S) && acc;
  assign w_hold    = (r_fsm == REQ_S) && !acc;
  assign w_cnt_clr = init || !w_conn || w_acc;

  eth_vlg_sat_cnt #(
    .W   (TW),
    .MAX (TIMEOUT)
  ) u_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_cnt_clr),
    .i_inc (w_live && r_fsm == DLY_S),
    .o_cnt (w_tmr)
  );

  eth_vlg_sat_cnt #(
    .W   (CW),
    .MAX (FORCE_ACK_PACKETS)
  ) u_pkt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_cnt_clr),
    .i_inc (w_live && pkt_rx),
    .o_cnt (w_pkt_cnt)
  );

  // Count includes this cycle's packet so the threshold fires without lag
  assign w_fire = upd
    || (({1'b0, w_pkt_cnt} + (CW + 1)'(pkt_rx))
        >= (CW + 1)'(FORCE_ACK_PACKETS))
    || (w_tmr == TW'(TIMEOUT));

  assign w_go_req = ((r_fsm == IDLE_S) && upd)
                 || ((r_fsm == DLY_S) && w_fire);
  assign w_go_dly = (r_fsm == IDLE_S) && !upd
                 && ((loc_ack != r_sent_ack) || pkt_rx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm      <= IDLE_S;
      r_sent_ack <= '0;
      r_pend     <= 1'b0;
      r_req      <= 1'b0;
      r_req_ack  <= '0;
      r_req_sack <= '0;
    end else if (init) begin
      r_fsm      <= IDLE_S;
      r_sent_ack <= init_ack;
      r_pend     <= 1'b0;
      r_req      <= 1'b0;
    end else if (!w_conn) begin
      r_fsm      <= IDLE_S;
      r_pend     <= 1'b0;
      r_req      <= 1'b0;
      r_req_ack  <= '0;
      r_req_sack <= '0;
    end else begin
      unique case (1'b1)
        w_go_req: begin
          r_fsm      <= REQ_S;
          r_req      <= 1'b1;
          r_req_ack  <= loc_ack;
          r_req_sack <= sack;
        end
        w_go_dly: r_fsm <= DLY_S;
        w_acc: begin
          r_req      <= 1'b0;
          r_sent_ack <= r_req_ack;
          r_pend     <= 1'b0;
          r_fsm      <= (r_pend || upd || pkt_rx
                         || loc_ack != r_req_ack) ? DLY_S : IDLE_S;
        end
        w_hold: r_pend <= r_pend | upd | pkt_rx;
        default: ;
      endcase
    end
  end

  assign req      = r_req;
  assign req_ack  = r_req_ack;
  assign req_sack = r_req_sack;

endmodule
